// File: rtl/regfile_ctrl_pkg.sv
// Shared widths, the writeback request record and a small decode helper
// for the register-file write-port arbiter.
package regfile_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;
  localparam int WB_REQ_W   = REG_ADDR_W + XLEN;

  // One pending writeback: destination register plus result data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // One-hot mask selecting register 'a' in a NUM_REGS-wide bit vector.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency writebacks.
// Push side: transfer = push_valid & push_ready, push_ready = !full.
// Pop side: 'pop' is a strobe, honoured only when not empty; pop_data is the
// current head and is valid whenever empty is low.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full;
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register file's single write port. The WB stage always wins;
// long-latency results wait in wb_fifo and drain on free cycles. A pending
// write scoreboard feeds decode hazard detection, and a starvation counter
// asks the pipeline to back off when the FIFO has been blocked too long.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int LU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  starve_stall,
  output logic                  err_waw,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_data
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  // Long-latency handshake: transfer = lu_valid & lu_ready. lu_ready is
  // !full, forced low during reset. A transfer to x0 is accepted but never
  // stored, so it costs no FIFO slot and no port cycle.
  wb_req_t               push_req;
  wb_req_t               head_req;
  logic [WB_REQ_W-1:0]   head_bits;
  logic                  fifo_push_valid;
  logic                  fifo_push_ready;
  logic                  fifo_empty;
  logic                  pop;
  logic                  pipe_win;
  logic                  waw_issue;
  logic                  waw_pipe;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
  logic [XLEN-1:0]       rf_rd_data_q, rf_rd_data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  err_waw_q, err_waw_d;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  starve_stall_q, starve_stall_d;

  assign push_req        = {lu_rd, lu_data};
  assign head_req        = head_bits;
  assign fifo_push_valid = lu_valid && (lu_rd != '0) && !rst;
  assign lu_ready        = fifo_push_ready && !rst;

  wb_fifo #(
    .WIDTH (WB_REQ_W),
    .DEPTH (LU_FIFO_DEPTH)
  ) u_lu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (fifo_push_valid),
    .push_ready (fifo_push_ready),
    .push_data  (push_req),
    .pop        (pop),
    .pop_data   (head_bits),
    .empty      (fifo_empty)
  );

  // Port arbitration: WB stage first, FIFO head on otherwise-free cycles.
  always_comb begin
    pipe_win     = pipe_we && (pipe_rd != '0);
    pop          = !pipe_win && !fifo_empty;
    rf_we_d      = pipe_win || pop;
    rf_rd_addr_d = rf_rd_addr_q;
    rf_rd_data_d = rf_rd_data_q;
    if (pipe_win) begin
      rf_rd_addr_d = pipe_rd;
      rf_rd_data_d = pipe_data;
    end else if (pop) begin
      rf_rd_addr_d = head_req.rd;
      rf_rd_data_d = head_req.data;
    end
  end

  // Scoreboard: clear on FIFO pop, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d = busy_d & ~reg_onehot(head_req.rd);
    if (issue_valid && (issue_rd != '0)) busy_d = busy_d | reg_onehot(issue_rd);
    busy_d[0] = 1'b0;
    waw_issue = issue_valid && (issue_rd != '0) && busy_q[issue_rd];
    waw_pipe  = pipe_we && (pipe_rd != '0) && busy_q[pipe_rd];
    err_waw_d = err_waw_q || waw_issue || waw_pipe;
  end

  // Starvation: count cycles where the FIFO holds data but pipe takes the
  // port. The stall flag reflects the updated count, so it rises right
  // after the STARVE_LIMIT-th blocked cycle.
  always_comb begin
    starve_cnt_d = '0;
    if (!fifo_empty && pipe_win) begin
      if (starve_cnt_q == SC_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q;
      else                                     starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
    starve_stall_d = (starve_cnt_d == SC_W'(STARVE_LIMIT));
  end

  // All control state; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q        <= 1'b0;
      rf_rd_addr_q   <= '0;
      rf_rd_data_q   <= '0;
      busy_q         <= '0;
      err_waw_q      <= 1'b0;
      starve_cnt_q   <= '0;
      starve_stall_q <= 1'b0;
    end else begin
      rf_we_q        <= rf_we_d;
      rf_rd_addr_q   <= rf_rd_addr_d;
      rf_rd_data_q   <= rf_rd_data_d;
      busy_q         <= busy_d;
      err_waw_q      <= err_waw_d;
      starve_cnt_q   <= starve_cnt_d;
      starve_stall_q <= starve_stall_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_rd_addr   = rf_rd_addr_q;
  assign rf_rd_data   = rf_rd_data_q;
  assign busy_mask    = busy_q;
  assign err_waw      = err_waw_q;
  assign starve_stall = starve_stall_q;
  assign hazard       = busy_q[rs1_addr] | busy_q[rs2_addr];

endmodule
